// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module   : gray_counter
//  Purpose  : Registered up/down Gray-code counter with synchronous load,
//             wrap/saturate mode and a registered terminal-count flag.
//             Optional macro GRAY_CNT_BIN_OUT_EN exposes the binary count.
//  Revision : 1.0  initial release
// ============================================================================
module gray_counter #(
    parameter int BIT_WIDTH = 4,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] load_bin,
    output logic [BIT_WIDTH-1:0] gray_out,
    output logic                 tc
`ifdef GRAY_CNT_BIN_OUT_EN
    ,
    output logic [BIT_WIDTH-1:0] bin_out
`endif
);

    localparam logic [BIT_WIDTH-1:0] c_MAX        = '1;
    localparam logic [BIT_WIDTH-1:0] c_ONE        = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] c_RESET_BIN  = BIT_WIDTH'(RESET_VAL);
    localparam logic [BIT_WIDTH-1:0] c_RESET_GRAY = c_RESET_BIN ^ (c_RESET_BIN >> 1);

    logic [BIT_WIDTH-1:0] r_bin;
    logic [BIT_WIDTH-1:0] r_gray;
    logic                 r_tc;

    logic [BIT_WIDTH-1:0] w_next_bin;
    logic [BIT_WIDTH-1:0] w_next_gray;
    logic                 w_next_tc;

    always_comb begin
        w_next_bin = r_bin;
        w_next_tc  = 1'b0;
        if (load) begin
            w_next_bin = load_bin;
        end else if (en) begin
            if (up_dn) begin
                if (r_bin == c_MAX) begin
                    w_next_tc  = 1'b1;
                    w_next_bin = (SATURATE != 0) ? c_MAX : '0;
                end else begin
                    w_next_bin = r_bin + c_ONE;
                end
            end else begin
                if (r_bin == '0) begin
                    w_next_tc  = 1'b1;
                    w_next_bin = (SATURATE != 0) ? '0 : c_MAX;
                end else begin
                    w_next_bin = r_bin - c_ONE;
                end
            end
        end
    end

    // Gray is encoded ahead of the flop so the port toggles cleanly.
    assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= c_RESET_BIN;
            r_gray <= c_RESET_GRAY;
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_tc   <= w_next_tc;
        end
    end

    assign gray_out = r_gray;
    assign tc       = r_tc;

`ifdef GRAY_CNT_BIN_OUT_EN
    assign bin_out = r_bin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_counter
//  Purpose  : Self-checking bench; a wrapping counter (RESET_VAL=0) and a
//             saturating counter (RESET_VAL=5) share one stimulus stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gray_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic         up_dn = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] gray0, gray1;
    logic         tc0, tc1;
`ifdef GRAY_CNT_BIN_OUT_EN
    logic [W-1:0] bin0, bin1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integer count per DUT
    int m_cnt   [2];
    bit m_tc    [2];
    bit m_moved [2];
    logic [W-1:0] prev_g0, prev_g1;

    always #5 clk = ~clk;

    gray_counter #(.BIT_WIDTH(W), .RESET_VAL(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin), .gray_out(gray0), .tc(tc0)
`ifdef GRAY_CNT_BIN_OUT_EN
        , .bin_out(bin0)
`endif
    );

    gray_counter #(.BIT_WIDTH(W), .RESET_VAL(5), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_bin(load_bin), .gray_out(gray1), .tc(tc1)
`ifdef GRAY_CNT_BIN_OUT_EN
        , .bin_out(bin1)
`endif
    );

    function automatic logic [W-1:0] gray_of(input int v);
        logic [W-1:0] b;
        b = W'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_reset();
        m_cnt[0] = 0;  m_cnt[1] = 5;
        m_tc[0]  = 0;  m_tc[1]  = 0;
    endtask

    // Drives one clock's inputs, advances the model, returns #1 after the edge.
    task automatic cycle(input bit e, input bit u, input bit l, input logic [W-1:0] lb);
        int n, old;
        en = e; up_dn = u; load = l; load_bin = lb;
        prev_g0 = gray0; prev_g1 = gray1;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            old = m_cnt[k];
            if (l) begin
                m_cnt[k] = int'(lb);
                m_tc[k]  = 0;
            end else if (e) begin
                n = old + (u ? 1 : -1);
                if (n < 0 || n > MAXV) begin
                    m_tc[k] = 1;
                    if (k == 1) n = (n < 0) ? 0 : MAXV;
                    else        n = (n + MAXV + 1) % (MAXV + 1);
                end else begin
                    m_tc[k] = 0;
                end
                m_cnt[k] = n;
            end else begin
                m_tc[k] = 0;
            end
            m_moved[k] = (m_cnt[k] != old);
        end
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (gray0 !== 4'b0000) begin n_fail++; $display("FAIL reset_gray0: got %b expected %b", gray0, 4'b0000); end
        n_checks++; if (tc0 !== 1'b0) begin n_fail++; $display("FAIL reset_tc0: got %b expected 0", tc0); end
        n_checks++; if (gray1 !== 4'b0111) begin n_fail++; $display("FAIL reset_gray1: got %b expected %b", gray1, 4'b0111); end
        n_checks++; if (tc1 !== 1'b0) begin n_fail++; $display("FAIL reset_tc1: got %b expected 0", tc1); end
        cycle(1, 1, 0, 4'h0);
        n_checks++; if (gray0 !== 4'b0000) begin n_fail++; $display("FAIL reset_held_gray0: got %b expected %b", gray0, 4'b0000); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_wrap_up();
        logic [W-1:0] seq [17];
        seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 1, 0, 4'h0);
            n_checks++; if (gray0 !== seq[i]) begin n_fail++; $display("FAIL wrap_up_gray step %0d: got %h expected %h", i, gray0, seq[i]); end
            n_checks++; if (tc0 !== (i == 16)) begin n_fail++; $display("FAIL wrap_up_tc step %0d: got %b expected %b", i, tc0, (i == 16)); end
            n_checks++; if ($countones(gray0 ^ prev_g0) != 1) begin n_fail++; $display("FAIL wrap_up_hamming step %0d: got %0d expected 1", i, $countones(gray0 ^ prev_g0)); end
            n_checks++; if (gray1 !== gray_of(m_cnt[1]) || tc1 !== m_tc[1]) begin n_fail++; $display("FAIL wrap_up_sat step %0d: got %h/%b expected %h/%b", i, gray1, tc1, gray_of(m_cnt[1]), m_tc[1]); end
        end
    endtask

    task automatic test_wrap_down();
        cycle(1, 0, 0, 4'h0);
        n_checks++; if (gray0 !== 4'b1000 || tc0 !== 1'b1) begin n_fail++; $display("FAIL wrap_down_first: got %b/%b expected 1000/1", gray0, tc0); end
        n_checks++; if (gray1 !== gray_of(m_cnt[1]) || tc1 !== m_tc[1]) begin n_fail++; $display("FAIL wrap_down_sat: got %h/%b expected %h/%b", gray1, tc1, gray_of(m_cnt[1]), m_tc[1]); end
        cycle(1, 0, 0, 4'h0);
        n_checks++; if (gray0 !== 4'b1001 || tc0 !== 1'b0) begin n_fail++; $display("FAIL wrap_down_second: got %b/%b expected 1001/0", gray0, tc0); end
    endtask

    task automatic test_saturate();
        cycle(0, 0, 1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 4'h0);
            n_checks++; if (gray1 !== 4'b1000 || tc1 !== 1'b1) begin n_fail++; $display("FAIL saturate_hold %0d: got %b/%b expected 1000/1", i, gray1, tc1); end
            n_checks++; if (gray0 !== gray_of(m_cnt[0]) || tc0 !== m_tc[0]) begin n_fail++; $display("FAIL saturate_wrapdut %0d: got %h/%b expected %h/%b", i, gray0, tc0, gray_of(m_cnt[0]), m_tc[0]); end
        end
        cycle(1, 0, 0, 4'h0);
        n_checks++; if (gray1 !== 4'b1001 || tc1 !== 1'b0) begin n_fail++; $display("FAIL saturate_release: got %b/%b expected 1001/0", gray1, tc1); end
    endtask

    task automatic test_load_priority();
        cycle(1, 1, 1, 4'h9);
        n_checks++; if (gray0 !== 4'b1101 || tc0 !== 1'b0) begin n_fail++; $display("FAIL load_gray0: got %b/%b expected 1101/0", gray0, tc0); end
        n_checks++; if (gray1 !== 4'b1101 || tc1 !== 1'b0) begin n_fail++; $display("FAIL load_gray1: got %b/%b expected 1101/0", gray1, tc1); end
`ifdef GRAY_CNT_BIN_OUT_EN
        n_checks++; if (bin0 !== 4'd9 || bin1 !== 4'd9) begin n_fail++; $display("FAIL load_bin_out: got %0d/%0d expected 9/9", bin0, bin1); end
`endif
        cycle(1, 0, 1, 4'hF);
        n_checks++; if (gray0 !== 4'b1000 || tc0 !== 1'b0) begin n_fail++; $display("FAIL load_over_en: got %b/%b expected 1000/0", gray0, tc0); end
    endtask

    task automatic test_hold();
        cycle(1, 1, 0, 4'h0);
        n_checks++; if (gray0 !== 4'b0000 || tc0 !== 1'b1) begin n_fail++; $display("FAIL hold_wrap: got %b/%b expected 0000/1", gray0, tc0); end
        for (int i = 0; i < 3; i++) begin
            cycle(0, i[0], 0, 4'h5);
            n_checks++; if (gray0 !== prev_g0 || tc0 !== 1'b0) begin n_fail++; $display("FAIL hold_gray0 %0d: got %b/%b expected %b/0", i, gray0, tc0, prev_g0); end
            n_checks++; if (gray1 !== prev_g1 || tc1 !== 1'b0) begin n_fail++; $display("FAIL hold_gray1 %0d: got %b/%b expected %b/0", i, gray1, tc1, prev_g1); end
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 1, 4'h7);
        n_checks++; if (gray0 !== 4'b0100) begin n_fail++; $display("FAIL mid_load7: got %b expected 0100", gray0); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (gray0 !== 4'b0000 || tc0 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_gray0: got %b/%b expected 0000/0", gray0, tc0); end
        n_checks++; if (gray1 !== 4'b0111 || tc1 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_gray1: got %b/%b expected 0111/0", gray1, tc1); end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 1, 0, 4'h0);
        n_checks++; if (gray0 !== 4'b0001) begin n_fail++; $display("FAIL mid_first_step0: got %b expected 0001", gray0); end
        n_checks++; if (gray1 !== 4'b0101) begin n_fail++; $display("FAIL mid_first_step1: got %b expected 0101", gray1); end
    endtask

    task automatic test_random();
        bit e, u, l;
        logic [W-1:0] lb;
        for (int i = 0; i < 400; i++) begin
            l  = ($urandom_range(0, 11) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = ((i / 24) % 2 == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
            lb = W'($urandom);
            cycle(e, u, l, lb);
            n_checks++; if (gray0 !== gray_of(m_cnt[0]) || tc0 !== m_tc[0]) begin n_fail++; $display("FAIL rand_wrap cyc %0d: got %h/%b expected %h/%b", i, gray0, tc0, gray_of(m_cnt[0]), m_tc[0]); end
            n_checks++; if (gray1 !== gray_of(m_cnt[1]) || tc1 !== m_tc[1]) begin n_fail++; $display("FAIL rand_sat cyc %0d: got %h/%b expected %h/%b", i, gray1, tc1, gray_of(m_cnt[1]), m_tc[1]); end
            if (e && !l) begin
                n_checks++; if ($countones(gray0 ^ prev_g0) != 1) begin n_fail++; $display("FAIL rand_hamming0 cyc %0d: got %0d expected 1", i, $countones(gray0 ^ prev_g0)); end
                n_checks++; if ($countones(gray1 ^ prev_g1) != (m_moved[1] ? 1 : 0)) begin n_fail++; $display("FAIL rand_hamming1 cyc %0d: got %0d expected %0d", i, $countones(gray1 ^ prev_g1), m_moved[1] ? 1 : 0); end
            end
`ifdef GRAY_CNT_BIN_OUT_EN
            n_checks++; if (bin0 !== W'(m_cnt[0]) || bin0 !== g2b(gray0)) begin n_fail++; $display("FAIL rand_bin0 cyc %0d: got %0d expected %0d", i, bin0, m_cnt[0]); end
            n_checks++; if (bin1 !== W'(m_cnt[1]) || bin1 !== g2b(gray1)) begin n_fail++; $display("FAIL rand_bin1 cyc %0d: got %0d expected %0d", i, bin1, m_cnt[1]); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load_priority();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
